// File: rtl/axi_lite_bram_ctrl_if.sv
// ============================================================================
//  Module      : axi_lite_bram_ctrl_if
//  Description : AXI4-Lite slave-side bus bundle for axi_lite_bram_ctrl.
//                The slave modport is used by the controller and the master
//                modport by whoever issues the transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_bram_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

`default_nettype wire

// File: rtl/axi_lite_bram_ctrl.sv
// ============================================================================
//  Module      : axi_lite_bram_ctrl
//  Description : AXI4-Lite slave bridging onto one single-port, byte-writable
//                BRAM port with one cycle of read latency. Reads and writes
//                are serialised; simultaneous requests alternate by a
//                priority flag that resets to read-first.
//                Optional macro BRAM_CTRL_RANGE_CHECK_EN: accesses with word
//                address >= MEM_WORDS skip the BRAM and answer SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_bram_ctrl #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 16384
) (
  input  wire logic                      s_axi_aclk,
  input  wire logic                      s_axi_aresetn,
  axi_lite_bram_ctrl_if.slave            s_axi,
  output logic                           bram_rst_a,
  output logic                           bram_clk_a,
  output logic                           bram_en_a,
  output logic [DATA_WIDTH/8-1:0]        bram_we_a,
  output logic [ADDR_WIDTH-1:0]          bram_addr_a,
  output logic [DATA_WIDTH-1:0]          bram_wrdata_a,
  input  wire logic [DATA_WIDTH-1:0]     bram_rddata_a
);

  localparam int C_STRB = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_ACCESS  = 3'd1;
  localparam logic [2:0] S_WR_RESP    = 3'd2;
  localparam logic [2:0] S_RD_ACCESS  = 3'd3;
  localparam logic [2:0] S_RD_CAPTURE = 3'd4;
  localparam logic [2:0] S_RD_RESP    = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  r_rd_first;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [C_STRB-1:0]     r_wstrb;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_oob;

  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_req_oob;

  // BRAM clock/reset are straight pass-throughs of the AXI clock/reset
  assign bram_clk_a    = s_axi_aclk;
  assign bram_rst_a    = ~s_axi_aresetn;
  assign bram_addr_a   = r_addr;
  assign bram_wrdata_a = r_wdata;
  assign s_axi.rdata   = r_rdata;

  // A write needs both AW and W; on a tie the priority flag picks the type
  assign w_wr_elig  = s_axi.awvalid & s_axi.wvalid;
  assign w_rd_elig  = s_axi.arvalid;
  assign w_grant_rd = (r_state == S_IDLE) & w_rd_elig & (~w_wr_elig | r_rd_first);
  assign w_grant_wr = (r_state == S_IDLE) & w_wr_elig & (~w_rd_elig | ~r_rd_first);
  assign w_req_addr = w_grant_wr ? s_axi.awaddr : s_axi.araddr;

`ifdef BRAM_CTRL_RANGE_CHECK_EN
  // Word index compared against the implemented depth
  assign w_req_oob = (32'(w_req_addr >> 2) >= MEM_WORDS);
`else
  assign w_req_oob = 1'b0;
`endif

  // State register
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_rd) begin
          w_next = S_RD_ACCESS;
        end else if (w_grant_wr) begin
          w_next = S_WR_ACCESS;
        end
      end
      S_WR_ACCESS:  w_next = S_WR_RESP;
      S_WR_RESP:    if (s_axi.bready) w_next = S_IDLE;
      S_RD_ACCESS:  w_next = S_RD_CAPTURE;
      S_RD_CAPTURE: w_next = S_RD_RESP;
      S_RD_RESP:    if (s_axi.rready) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Handshake and BRAM strobe outputs decoded from the current state
  always_comb begin
    s_axi.awready = w_grant_wr;
    s_axi.wready  = w_grant_wr;
    s_axi.arready = w_grant_rd;
    s_axi.bvalid  = (r_state == S_WR_RESP);
    s_axi.rvalid  = (r_state == S_RD_RESP);
    s_axi.bresp   = ((r_state == S_WR_RESP) && r_oob) ? 2'b10 : 2'b00;
    s_axi.rresp   = ((r_state == S_RD_RESP) && r_oob) ? 2'b10 : 2'b00;
    bram_en_a     = ((r_state == S_WR_ACCESS) || (r_state == S_RD_ACCESS)) && !r_oob;
    bram_we_a     = ((r_state == S_WR_ACCESS) && !r_oob) ? r_wstrb : '0;
  end

  // Request capture, read-data capture and the tie-break flag
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_oob      <= 1'b0;
      r_rd_first <= 1'b1;
    end else begin
      if (w_grant_wr || w_grant_rd) begin
        r_addr <= {w_req_addr[ADDR_WIDTH-1:2], 2'b00};
        r_oob  <= w_req_oob;
      end
      if (w_grant_wr) begin
        r_wdata    <= s_axi.wdata;
        r_wstrb    <= s_axi.wstrb;
        r_rd_first <= 1'b1;
      end
      if (w_grant_rd) begin
        r_rd_first <= 1'b0;
      end
      // Out-of-range reads never touched the BRAM, so they return zero
      if (r_state == S_RD_CAPTURE) begin
        r_rdata <= r_oob ? '0 : bram_rddata_a;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_bram_ctrl.sv
// ============================================================================
//  Module      : tb_axi_lite_bram_ctrl
//  Description : Self-checking bench for axi_lite_bram_ctrl. A transaction-
//                level reference (memory image + cycles-since-grant) predicts
//                every output each cycle; directed tasks add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_bram_ctrl;

`ifdef BRAM_CTRL_RANGE_CHECK_EN
  localparam int MW = 4096;
`else
  localparam int MW = 16384;
`endif

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_bram_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  logic        bram_rst_a, bram_clk_a, bram_en_a;
  logic [3:0]  bram_we_a;
  logic [15:0] bram_addr_a;
  logic [31:0] bram_wrdata_a;
  logic [31:0] bram_rddata_a = 32'h0;

  axi_lite_bram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(MW)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(aresetn),
    .s_axi        (bus),
    .bram_rst_a   (bram_rst_a),
    .bram_clk_a   (bram_clk_a),
    .bram_en_a    (bram_en_a),
    .bram_we_a    (bram_we_a),
    .bram_addr_a  (bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a),
    .bram_rddata_a(bram_rddata_a)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endfunction

  function automatic bit is_oob(input int w);
`ifdef BRAM_CTRL_RANGE_CHECK_EN
    return (w >= MW);
`else
    return (w < 0);
`endif
  endfunction

  // Single-port BRAM with one cycle read latency
  logic [31:0] bram_mem [int];
  int          bw;
  logic [31:0] bcur;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (bram_en_a) begin
      bw   = int'(bram_addr_a >> 2);
      bcur = bram_mem.exists(bw) ? bram_mem[bw] : 32'h0;
      bram_rddata_a <= bcur;
      for (int b = 0; b < 4; b++)
        if (bram_we_a[b]) bcur[8*b +: 8] = bram_wrdata_a[8*b +: 8];
      if (bram_we_a != 4'h0) bram_mem[bw] = bcur;
    end
  end

  // Reference model: memory image plus "age" of the outstanding transaction
  logic [31:0] ref_mem [int];
  bit          m_busy = 0, m_wr = 0, m_err = 0, m_rd_first = 1, m_rst_seen = 1;
  int          m_age = 0, m_word;
  logic [15:0] m_addr = 16'h0;
  logic [31:0] m_wdata = 32'h0, m_exp_rdata = 32'h0, m_tmp;
  logic [3:0]  m_strb = 4'h0;
  bit          e_gr, e_gw, e_acc, e_bv, e_rv;

  // Per-cycle comparison, then advance the model to the next cycle
  always @(negedge clk) begin
    e_gr  = !m_busy && bus.arvalid && !(bus.awvalid && bus.wvalid && !m_rd_first);
    e_gw  = !m_busy && bus.awvalid && bus.wvalid && !(bus.arvalid && m_rd_first);
    e_acc = m_busy && (m_age == 1) && !m_err;
    e_bv  = m_busy && m_wr && (m_age >= 2);
    e_rv  = m_busy && !m_wr && (m_age >= 3);
    chk("awready", bus.awready, e_gw);
    chk("wready", bus.wready, e_gw);
    chk("arready", bus.arready, e_gr);
    chk("bram_en", bram_en_a, e_acc);
    chk("bram_we", bram_we_a, (e_acc && m_wr) ? m_strb : 4'h0);
    chk("bram_rst", bram_rst_a, !aresetn);
    chk("bram_clk", bram_clk_a, clk);
    if (e_acc) chk("bram_addr", bram_addr_a, m_addr);
    if (e_acc && m_wr) chk("bram_wrdata", bram_wrdata_a, m_wdata);
    chk("bvalid", bus.bvalid, e_bv);
    chk("rvalid", bus.rvalid, e_rv);
    if (e_bv) chk("bresp", bus.bresp, m_err ? 2'b10 : 2'b00);
    if (e_rv) begin
      chk("rresp", bus.rresp, m_err ? 2'b10 : 2'b00);
      chk("rdata", bus.rdata, m_exp_rdata);
    end
    if (m_rst_seen) begin
      chk("rst_bresp", bus.bresp, 0);
      chk("rst_rresp", bus.rresp, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_addr", bram_addr_a, 0);
      chk("rst_wrdata", bram_wrdata_a, 0);
    end
    if (!aresetn) begin
      m_busy = 0; m_age = 0; m_err = 0; m_rd_first = 1; m_rst_seen = 1;
    end else begin
      m_rst_seen = 0;
      if (e_gr) begin
        m_word      = int'(bus.araddr >> 2);
        m_err       = is_oob(m_word);
        m_addr      = {bus.araddr[15:2], 2'b00};
        m_exp_rdata = (m_err || !ref_mem.exists(m_word)) ? 32'h0 : ref_mem[m_word];
        m_busy = 1; m_wr = 0; m_age = 1; m_rd_first = 0;
      end else if (e_gw) begin
        m_word  = int'(bus.awaddr >> 2);
        m_err   = is_oob(m_word);
        m_addr  = {bus.awaddr[15:2], 2'b00};
        m_wdata = bus.wdata;
        m_strb  = bus.wstrb;
        if (!m_err) begin
          m_tmp = ref_mem.exists(m_word) ? ref_mem[m_word] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (m_strb[b]) m_tmp[8*b +: 8] = m_wdata[8*b +: 8];
          ref_mem[m_word] = m_tmp;
        end
        m_busy = 1; m_wr = 1; m_age = 1; m_rd_first = 1;
      end else if (m_busy) begin
        if ((e_bv && bus.bready) || (e_rv && bus.rready)) m_busy = 0;
        else m_age++;
      end
    end
  end

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic en_s, output logic [3:0] we_s,
                           output logic [15:0] ad_s, output int hs);
    int n;
    @(posedge clk); #1;
    bus.awaddr = a; bus.awvalid = 1'b1; bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.awready) break;
      n++;
      if (n > 100) begin chk("aw_timeout", 1, 0); break; end
    end
    hs = edge_cnt;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    en_s = bram_en_a; we_s = bram_we_a; ad_s = bram_addr_a;
    lat = 1;
    while (!bus.bvalid && lat < 100) begin @(negedge clk); lat++; end
    if (!bus.bvalid) chk("b_timeout", 1, 0);
    @(posedge clk);
  endtask

  task automatic axi_read(input logic [15:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] r, output int lat,
                          output logic en_s, output logic [15:0] ad_s, output int hs);
    int n;
    @(posedge clk); #1;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = (hold == 0);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.arready) break;
      n++;
      if (n > 100) begin chk("ar_timeout", 1, 0); break; end
    end
    hs = edge_cnt;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    en_s = bram_en_a; ad_s = bram_addr_a;
    lat = 1;
    while (!bus.rvalid && lat < 100) begin @(negedge clk); lat++; end
    if (!bus.rvalid) chk("r_timeout", 1, 0);
    d = bus.rdata; r = bus.rresp;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_rvalid", bus.rvalid, 1);
        chk("hold_rdata", bus.rdata, d);
      end
      @(posedge clk); #1;
      bus.rready = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  logic [31:0] d, d2;
  logic [1:0]  r, r2;
  int          lat, lat2, hs, hs2;
  logic        en_s, en_s2;
  logic [3:0]  we_s;
  logic [15:0] ad_s, ad_s2;

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0;
    bus.rready = 0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    chk("rst_en", bram_en_a, 0);
    chk("rst_bvalid", bus.bvalid, 0);

    // Full-word write then read back
    axi_write(16'h1234, 32'hDEADBEEF, 4'hF, lat, en_s, we_s, ad_s, hs);
    chk("w1_en", en_s, 1);
    chk("w1_we", we_s, 4'hF);
    chk("w1_addr", ad_s, 16'h1234);
    chk("w1_blat", lat, 2);
    axi_read(16'h1234, 0, d, r, lat, en_s, ad_s, hs);
    chk("r1_data", d, 32'hDEADBEEF);
    chk("r1_resp", r, 2'b00);
    chk("r1_lat", lat, 3);
    chk("r1_en", en_s, 1);

    // Byte-lane merge and unaligned read address
    axi_write(16'h0040, 32'h11223344, 4'hF, lat, en_s, we_s, ad_s, hs);
    axi_write(16'h0040, 32'hAABBCCDD, 4'b0010, lat, en_s, we_s, ad_s, hs);
    chk("w2_we", we_s, 4'b0010);
    axi_read(16'h0042, 0, d, r, lat, en_s, ad_s, hs);
    chk("r2_addr", ad_s, 16'h0040);
    chk("r2_data", d, 32'h1122CC44);

    // Zero-strobe write still runs a BRAM cycle and responds
    axi_write(16'h0040, 32'hFFFFFFFF, 4'h0, lat, en_s, we_s, ad_s, hs);
    chk("w0_en", en_s, 1);
    chk("w0_we", we_s, 4'h0);
    chk("w0_blat", lat, 2);
    axi_read(16'h0040, 0, d, r, lat, en_s, ad_s, hs);
    chk("r0_data", d, 32'h1122CC44);

    // Simultaneous AW/W/AR after reset: read wins and sees the old value
    do_reset();
    fork
      axi_write(16'h1234, 32'h55555555, 4'hF, lat2, en_s2, we_s, ad_s2, hs2);
      axi_read(16'h1234, 0, d, r, lat, en_s, ad_s, hs);
    join
    chk("tie_read_first", (hs < hs2), 1);
    chk("tie_rdata_old", d, 32'hDEADBEEF);
    axi_read(16'h1234, 0, d, r, lat, en_s, ad_s, hs);
    chk("tie_rdata_new", d, 32'h55555555);

    // Continuous contention; the model checks every grant
    fork
      begin
        axi_write(16'h0084, 32'h01020304, 4'hF, lat2, en_s2, we_s, ad_s2, hs2);
        axi_write(16'h0088, 32'h05060708, 4'hF, lat2, en_s2, we_s, ad_s2, hs2);
      end
      begin
        axi_read(16'h0084, 0, d2, r2, lat, en_s, ad_s, hs);
        axi_read(16'h0088, 0, d2, r2, lat, en_s, ad_s, hs);
      end
    join

    // Read response back-pressure
    axi_read(16'h1234, 5, d, r, lat, en_s, ad_s, hs);
    chk("hold_data", d, 32'h55555555);

    // Reset during the write response: write landed, response dropped
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.awaddr = 16'h0100; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.awready) break;
      if (i == 99) chk("mid_aw_timeout", 1, 0);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bvalid_before", bus.bvalid, 1);
    do_reset();
    @(negedge clk);
    chk("mid_bvalid_after", bus.bvalid, 0);
    axi_read(16'h0100, 0, d, r, lat, en_s, ad_s, hs);
    chk("mid_rdata", d, 32'hCAFEF00D);

`ifdef BRAM_CTRL_RANGE_CHECK_EN
    axi_read(16'h4000, 0, d, r, lat, en_s, ad_s, hs);
    chk("oob_en", en_s, 0);
    chk("oob_resp", r, 2'b10);
    chk("oob_data", d, 32'h0);
    chk("oob_lat", lat, 3);
    axi_read(16'h3FFC, 0, d, r, lat, en_s, ad_s, hs);
    chk("inb_resp", r, 2'b00);
    axi_write(16'h4000, 32'h12345678, 4'hF, lat, en_s, we_s, ad_s, hs);
    chk("oob_wen", en_s, 0);
    chk("oob_blat", lat, 2);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_lite_bram_ctrl.md
# axi_lite_bram_ctrl

AXI4-Lite slave that bridges a 32-bit AXI4-Lite port to one single-port byte-writable block RAM port with one cycle of read latency. The core's instruction-memory and data-memory buses each use one instance, driving one port of a shared dual-port RAM. The block serialises reads and writes onto the single BRAM port and always returns OKAY, unless the optional range check is compiled in.

## Interface
- ADDR_WIDTH, 16, AXI/BRAM byte-address width
- DATA_WIDTH, 32, data width (fixed 32; 4 strobes)
- MEM_WORDS, 16384, implemented words; used only by the range check
- s_axi_aclk  in  1  clock; all logic on rising edge; also forwarded as bram_clk_a
- s_axi_aresetn  in  1  reset, synchronous, active-low
- s_axi_awaddr  in  16  write address; s_axi_awprot in 3, ignored
- s_axi_awvalid in 1 / s_axi_awready out 1  write-address handshake
- s_axi_wdata in 32 / s_axi_wstrb in 4 / s_axi_wvalid in 1 / s_axi_wready out 1  write-data channel
- s_axi_bresp out 2 / s_axi_bvalid out 1 / s_axi_bready in 1  write response
- s_axi_araddr  in  16  read address; s_axi_arprot in 3, ignored
- s_axi_arvalid in 1 / s_axi_arready out 1  read-address handshake
- s_axi_rdata out 32 / s_axi_rresp out 2 / s_axi_rvalid out 1 / s_axi_rready in 1  read data
- bram_rst_a  out  1  = ~s_axi_aresetn
- bram_clk_a  out  1  = s_axi_aclk
- bram_en_a out 1 / bram_we_a out 4  port enable, byte write enables
- bram_addr_a  out  16  byte address, bits [1:0] forced 0
- bram_wrdata_a out 32 / bram_rddata_a in 32  BRAM data

## Operation
- States: IDLE, WR_ACCESS, WR_RESP, RD_ACCESS, RD_CAPTURE, RD_RESP.
- IDLE: a write is eligible only when awvalid and wvalid are both high. AW and W are always accepted in the same cycle.
- IDLE: a read is eligible when arvalid is high.
- Ready outputs are combinational and are high only in IDLE for the granted request. Outside IDLE, all three readies are 0.
- Tie (write and read both eligible): a priority flag decides. It resets to "read first" and, after every grant, points to the opposite transaction type. A lone eligible request is always granted.
- Write grant: register {awaddr[15:2],2'b00}, wdata and wstrb, then go to WR_ACCESS. WR_ACCESS drives en=1, we=wstrb, addr, wrdata for one cycle, then goes to WR_RESP. WR_RESP holds bvalid=1, bresp=00 until bready, then returns to IDLE.
- wstrb=0 still performs an en=1, we=0 cycle and still produces a response.
- Read grant: register the address, then go to RD_ACCESS. RD_ACCESS drives en=1, we=0 for one cycle. RD_CAPTURE latches bram_rddata_a into rdata. RD_RESP holds rvalid=1, rresp=00 and a stable rdata until rready, then returns to IDLE.
- bram_en_a is 0 in all states except WR_ACCESS and RD_ACCESS. bram_we_a is 0 except in WR_ACCESS.
- Reset values: all readies 0, bvalid/rvalid 0, bresp/rresp 00, rdata 0, bram_en_a 0, bram_we_a 0, bram_addr_a 0, bram_wrdata_a 0, state IDLE, priority flag = read-first.
- Reset mid-transaction: the transaction is abandoned and no response is issued. A BRAM write in progress completes only if its WR_ACCESS edge precedes reset.

## Timing
- Handshake edge = k.
- Write: BRAM write occurs at edge k+1. bvalid is visible after edge k+1. The earliest next acceptance is the cycle after the B handshake edge.
- Read: en is visible after edge k. Data is registered at edge k+2. rvalid is visible after edge k+2.
- Minimum occupancy: write 3 cycles, read 4 cycles (with bready/rready held high).
- Back-to-back alternating writes and reads are fair; neither type starves under continuous contention.

## Configuration
- BRAM_CTRL_RANGE_CHECK_EN defined: any access with word address ≥ MEM_WORDS skips the BRAM cycle (en stays 0) and responds SLVERR (2'b10).
  - Reads return rdata=0 with the same latency as a normal read.
  - Writes follow the normal write timing.
- Not defined: MEM_WORDS is ignored, every access goes to the BRAM, and every response is OKAY.

## Test plan
- Reset held 2 cycles, then released: all outputs equal their reset values; no ready is high while the valids are low.
- Write 0x0000_1234 → 0xDEADBEEF, wstrb=F; then read 0x1234: en/we=F/addr 0x1234 appear one cycle after the handshake; bvalid arrives 1 edge after; rdata=0xDEADBEEF with rvalid 2 edges after the AR handshake.
- Write 0x11223344 to 0x40, then wstrb=4'b0010 data 0xAABBCCDD, then read 0x42: addr 0x40 is driven and the read returns 0x1122CC44.
- AW, W and AR all valid simultaneously from reset, each held until accepted: the read is granted first, then the write; the read returns the pre-write value.
- Hold rready=0 for 5 cycles: rvalid and rdata stay stable, no readies assert, and the transaction completes when rready rises.
- With BRAM_CTRL_RANGE_CHECK_EN and MEM_WORDS=4096, read 0x4000: bram_en_a stays 0, rresp=10, rdata=0. Read 0x3FFC: rresp=00.
